// File: rtl/sub32_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// sub32_rr_arbiter_if
// Bundles the requester-side and response-side handshake of the shared
// 32-bit subtractor.
//   req_valid  [NREQ]      : requester i has an operand pair
//   req_ready  [NREQ]      : requester i's pair is accepted this cycle
//   req_a/req_b[NREQ*32]   : minuend/subtrahend, lane i at [32i+31:32i]
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id     [IDW]       : owning requester of the response
//   rsp_diff   [32]        : a - b modulo 2^32
//   rsp_overflow/borrow    : signed overflow / unsigned borrow
// The slave modport is the arbiter's view; master is the environment's view.
// ---------------------------------------------------------------------------
interface sub32_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_diff;
  logic               rsp_overflow;
  logic               rsp_borrow;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_overflow, rsp_borrow
  );
endinterface

// File: rtl/sub32_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sub32_rr_arbiter
// One 32-bit two's-complement subtractor shared between NREQ requesters.
// A round-robin arbiter grants one request per cycle whenever the single
// response register is empty or being drained; the granted pair's a - b,
// signed overflow and unsigned borrow are registered together with the
// requester index.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sub32_rr_arbiter_if.slave (request and response handshakes)
// ---------------------------------------------------------------------------
module sub32_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sub32_rr_arbiter_if.slave     bus
);

  localparam int             IW1      = IDW + 1;
  localparam logic [IDW:0]   NREQ_W   = IW1'(NREQ);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q;
  logic [31:0]    diff_q;
  logic           ov_q;
  logic           bw_q;

  logic           found_s;
  logic [IDW-1:0] gidx_s;
  logic           can_accept_s;
  logic           grant_s;
  logic [31:0]    a_sel_s;
  logic [31:0]    b_sel_s;
  logic [31:0]    diff_s;
  logic           carry_s;
  logic           ov_s;
  logic           bw_s;

  // Rotating priority search: first valid lane at or after ptr, wrapping.
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW:0] cand;
    logic         hit;
    found_s = 1'b0;
    gidx_s  = '0;
    sum     = '0;
    cand    = '0;
    hit     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum     = {1'b0, ptr_q} + IW1'(k);
      // ptr < NREQ and k < NREQ, so one subtraction is enough to wrap.
      cand    = (sum >= NREQ_W) ? (sum - NREQ_W) : sum;
      hit     = !found_s && bus.req_valid[cand[IDW-1:0]];
      gidx_s  = hit ? cand[IDW-1:0] : gidx_s;
      found_s = found_s | hit;
    end
  end

  // Shared subtractor on the granted lane: a + ~b + 1 with 33-bit carry.
  always_comb begin
    a_sel_s            = bus.req_a[{gidx_s, 5'd0} +: 32];
    b_sel_s            = bus.req_b[{gidx_s, 5'd0} +: 32];
    {carry_s, diff_s}  = {1'b0, a_sel_s} + {1'b0, ~b_sel_s} + 33'd1;
    bw_s               = ~carry_s;
    ov_s               = (a_sel_s[31] != b_sel_s[31]) && (diff_s[31] != a_sel_s[31]);
  end

  // Grant qualification, pointer and response-state next-state logic.
  always_comb begin
    can_accept_s  = (state_q == ST_EMPTY) || bus.rsp_ready;
    // rst_n gating keeps req_ready low for the whole reset interval.
    grant_s       = can_accept_s && found_s && rst_n;
    bus.req_ready = '0;
    ptr_d         = ptr_q;
    state_d       = state_q;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = grant_s && (gidx_s == IDW'(i));
    end
    if (grant_s) begin
      ptr_d = (gidx_s == LAST_IDX) ? '0 : (gidx_s + IDW'(1));
    end else begin
      ptr_d = ptr_q;
    end
    case (state_q)
      ST_EMPTY: state_d = grant_s ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (grant_s) begin
          state_d = ST_FULL;
        end else if (bus.rsp_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and priority pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Response data register: loads only on a grant, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      diff_q <= 32'd0;
      ov_q   <= 1'b0;
      bw_q   <= 1'b0;
    end else if (grant_s) begin
      id_q   <= gidx_s;
      diff_q <= diff_s;
      ov_q   <= ov_s;
      bw_q   <= bw_s;
    end else begin
      id_q   <= id_q;
      diff_q <= diff_q;
      ov_q   <= ov_q;
      bw_q   <= bw_q;
    end
  end

  assign bus.rsp_valid    = (state_q == ST_FULL);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_diff     = diff_q;
  assign bus.rsp_overflow = ov_q;
  assign bus.rsp_borrow   = bw_q;

endmodule
